// File: rtl/prbs10_checker.sv
// Serial checker for the x^10 + x^7 + 1 PRBS stream: self-synchronises, locks,
// counts errors while locked and drops lock on excessive error density.
module prbs10_checker #(
  parameter int LOCK_CNT    = 16,
  parameter int WINDOW      = 64,
  parameter int UNLOCK_ERRS = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             bit_valid_i,
  input  logic             bit_in_i,
  input  logic             clear_i,
  output logic             locked_o,
  output logic             err_pulse_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [CNT_W-1:0] bit_cnt_o
);

  localparam logic [0:0] ST_SEARCH = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam int MW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT + 1) : 1;
  localparam int WW = $clog2(WINDOW);
  localparam int EW = (UNLOCK_ERRS > 1) ? $clog2(UNLOCK_ERRS + 1) : 1;

  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
  localparam logic [WW-1:0] WIN_LAST   = WW'(WINDOW - 1);
  localparam logic [EW-1:0] ERR_LAST   = EW'(UNLOCK_ERRS - 1);

  logic [0:0]       state_q, state_d;
  logic [9:0]       hist_q, hist_d;
  logic [3:0]       fill_q, fill_d;
  logic [MW-1:0]    match_cnt_q, match_cnt_d;
  logic [WW-1:0]    win_cnt_q, win_cnt_d;
  logic [EW-1:0]    win_errs_q, win_errs_d;
  logic             err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             pred;
  logic             err;

  assign pred = hist_q[9] ^ hist_q[6];
  assign err  = bit_in_i ^ pred;

  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    fill_d      = fill_q;
    match_cnt_d = match_cnt_q;
    win_cnt_d   = win_cnt_q;
    win_errs_d  = win_errs_q;
    err_pulse_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    bit_cnt_d   = bit_cnt_q;

    if (bit_valid_i) begin
      if (state_q == ST_SEARCH) begin
        hist_d = {hist_q[8:0], bit_in_i};
        if (fill_q != 4'd10) begin
          fill_d = fill_q + 4'd1;
        end else if (err || (hist_q == 10'd0)) begin
          match_cnt_d = '0;
        end else if (match_cnt_q == MATCH_LAST) begin
          state_d     = ST_LOCKED;
          match_cnt_d = '0;
        end else begin
          match_cnt_d = match_cnt_q + MW'(1);
        end
      end else begin
        // Flywheel: keep regenerating the pattern so one flipped bit is one error.
        hist_d = {hist_q[8:0], pred};
        if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (err) begin
          err_pulse_d = 1'b1;
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
        end
        if (err && (win_errs_q == ERR_LAST)) begin
          state_d     = ST_SEARCH;
          fill_d      = 4'd0;
          match_cnt_d = '0;
          win_cnt_d   = '0;
          win_errs_d  = '0;
        end else if (win_cnt_q == WIN_LAST) begin
          win_cnt_d  = '0;
          win_errs_d = '0;
        end else begin
          win_cnt_d = win_cnt_q + WW'(1);
          if (err) win_errs_d = win_errs_q + EW'(1);
        end
      end
    end

    if (clear_i) begin
      err_cnt_d = '0;
      bit_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= ST_SEARCH;
      hist_q      <= '0;
      fill_q      <= '0;
      match_cnt_q <= '0;
      win_cnt_q   <= '0;
      win_errs_q  <= '0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
      bit_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      match_cnt_q <= match_cnt_d;
      win_cnt_q   <= win_cnt_d;
      win_errs_q  <= win_errs_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end

  assign locked_o    = (state_q == ST_LOCKED);
  assign err_pulse_o = err_pulse_q;
  assign err_cnt_o   = err_cnt_q;
  assign bit_cnt_o   = bit_cnt_q;

endmodule

// File: doc/prbs10_checker.md
# prbs10_checker

Serial PRBS checker for the 10-bit pattern x^10 + x^7 + 1 produced by the team's 10-bit LFSR generator. It is the receive end of that generator's link: the generator's serial output (the new bit0 feedback bit, one bit per cycle) drives `bit_in`. The block self-synchronises to the incoming stream and declares lock. Once locked, it counts bit errors and loses lock on an excessive error density. It sits at the receive side of link/BIST test paths and feeds status registers.

## Interface
- `LOCK_CNT`, 16: consecutive correct predictions required to enter LOCKED.
- `WINDOW`, 64: length in valid bits of the error-density window while LOCKED. Must be ≥ 2.
- `UNLOCK_ERRS`, 8: errors within one window that force return to SEARCH. Must be ≥ 1 and ≤ `WINDOW`.
- `CNT_W`, 16: width of `err_cnt` and `bit_cnt`.
- `clk` input 1: single clock. All logic is on the rising edge.
- `rst` input 1: reset, synchronous, active-low.
- `bit_valid` input 1: `bit_in` is sampled this cycle. No backpressure.
- `bit_in` input 1: received serial PRBS bit.
- `clear` input 1: synchronous clear of `err_cnt` and `bit_cnt`. Does not affect lock.
- `locked` output 1: state is LOCKED.
- `err_pulse` output 1: one-cycle pulse for each error detected while LOCKED.
- `err_cnt` output `CNT_W`: errors detected while LOCKED. Saturating.
- `bit_cnt` output `CNT_W`: valid bits checked while LOCKED. Saturating.

## Operation
- Recursion: b[n] = b[n-10] XOR b[n-7]. The block holds a 10-bit history register `hist`, with `hist[9]` the oldest bit. Prediction is `pred = hist[9] ^ hist[6]`. History shifts only on `bit_valid`.
- State SEARCH (reset state):
  - Each valid bit is shifted into `hist`.
  - `fill` counts from 0 to 10. Predictions are ignored until 10 bits have been loaded.
  - After fill, a match (`bit_in == pred`) increments `match_cnt`. A mismatch clears `match_cnt` to 0.
  - A match is not counted if `hist` is all zeros, because the all-zero state is illegal; `match_cnt` is cleared to 0 in that case.
  - When the `LOCK_CNT`-th consecutive match is sampled, the state goes to LOCKED.
- State LOCKED:
  - Each valid bit increments `bit_cnt` and is compared with `pred`. A mismatch is an error.
  - `hist` shifts in `pred`, not `bit_in` (flywheel). A single flipped bit therefore counts as exactly one error.
  - On an error: `err_pulse` asserts and `err_cnt` increments.
  - `win_cnt` runs from 0 to `WINDOW`-1 over valid bits. `win_errs` counts errors in the current window.
  - If `win_errs` plus the current error reaches `UNLOCK_ERRS`, the state goes to SEARCH. On that transition `fill`, `match_cnt`, `win_cnt` and `win_errs` are cleared to 0.
  - On the valid bit where `win_cnt == WINDOW-1`:
    - The error check on that bit, including a possible unlock, is evaluated first, against the old window.
    - Then `win_cnt` and `win_errs` both clear to 0.
- Counters: `err_cnt` and `bit_cnt` saturate at 2^`CNT_W`-1 and hold there. `clear` has priority over a same-cycle increment, so the result is 0.
- Cycles with `bit_valid` = 0 change no state and produce no pulse.

## Timing
- Reset with `rst` = 0 at a rising edge:
  - `locked` = 0, `err_pulse` = 0, `err_cnt` = 0, `bit_cnt` = 0.
  - State is SEARCH. `hist`, `fill`, `match_cnt`, `win_cnt` and `win_errs` are 0.
- Reset mid-operation has the same effect as reset, on the same edge.
- All outputs are registered.
  - `err_pulse` and the `err_cnt` increment appear the cycle after the erroneous bit is sampled.
  - `locked` rises the cycle after the `LOCK_CNT`-th match is sampled. It falls the cycle after the unlocking error is sampled.
- Lock latency on a clean stream: 10 + `LOCK_CNT` valid bits (26 by default).
- The unlocking error itself is counted: `err_cnt` increments and `err_pulse` fires.
- Back-to-back valid bits are supported at 1 bit per cycle. Throughput is 1 bit per cycle.

## Test plan
- Reset → all outputs 0 and `locked` = 0. Keep them there for 20 cycles with `bit_valid` = 0.
- Generator (seed 0x200) drives 100 consecutive valid bits → `locked` rises the cycle after valid bit 26. At the end `err_cnt` = 0 and `bit_cnt` = 74.
- After lock, invert one bit → exactly one `err_pulse` and `err_cnt` = 1. `locked` stays 1, and the following 50 bits produce no further errors.
- After lock, invert 8 consecutive bits → `locked` falls the cycle after the 8th error and `err_cnt` = 8. With a clean stream afterwards, `locked` relocks 26 valid bits later.
- Constant `bit_in` = 0 for 200 valid bits → `locked` stays 0 and `err_cnt` = 0. Repeat with random `bit_valid` gaps on the clean generator stream → lock after 26 valid bits, no errors.
- `clear` asserted in the same cycle as an error increment → `err_cnt` = 0. A separate case: `rst` asserted while LOCKED → all outputs 0 on the next cycle.
